l1_refill_ctrl: RTL and testbench

L1_REFILL_CTRL -- requirements
Module: l1_refill_ctrl

---
 rtl/l1_refill_pkg.sv | 20 ++
 rtl/l1_refill_ctrl.sv | 168 ++++++++++++++++
 tb/tb_l1_refill_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_refill_pkg.sv
// Shared state encoding and L1 access-mode constants for the L1 refill controller.
package l1_refill_pkg;

    localparam int LINE_WORDS = 16;

    localparam logic [1:0] MODE_READ  = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b11;
    localparam logic [1:0] MODE_IDLE  = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITE,
        MISS_REQ,
        FILL,
        REPLAY,
        RESP
    } state_t;

endpackage

// File: rtl/l1_refill_ctrl.sv
// Core-facing L1 access controller: serves reads/writes from L1 and, on a read miss,
// refills the whole line from L2 before replaying the lookup.
module l1_refill_ctrl #(
    parameter int LINE_WORDS = l1_refill_pkg::LINE_WORDS,
    parameter int DATA_W     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [1:0]        l1_mode,
    output logic [31:0]       l1_st,
    output logic [DATA_W-1:0] l1_in,
    input  logic [DATA_W-1:0] l1_out,
    input  logic              l1_miss,
    output logic              l2_req_valid,
    input  logic              l2_req_ready,
    output logic [31:0]       l2_req_addr,
    input  logic              l2_data_valid,
    input  logic [DATA_W-1:0] l2_data,
    output logic              busy
);
    import l1_refill_pkg::*;

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int BW    = OFF_W + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [BW-1:0] ALL_BEATS = BW'(LINE_WORDS);

    state_t            state, state_n;
    logic [31:0]       addr_q, addr_n;
    logic [BW-1:0]     beat, beat_n;
    logic [1:0]        l1_mode_n;
    logic [31:0]       l1_st_n;
    logic [DATA_W-1:0] l1_in_n;
    logic              l2_req_valid_n;
    logic [31:0]       l2_req_addr_n;
    logic              resp_valid_n;
    logic [DATA_W-1:0] resp_data_n;
    logic              resp_err_n;

    assign req_ready = rst_n && (state == IDLE);
    assign busy      = (state != IDLE);

    // All L1/L2-facing outputs are registered: next values are computed here and
    // the L1 sees each access one cycle after the decision that issued it.
    always_comb begin
        state_n        = state;
        addr_n         = addr_q;
        beat_n         = beat;
        l1_mode_n      = MODE_IDLE;
        l1_st_n        = l1_st;
        l1_in_n        = l1_in;
        l2_req_valid_n = l2_req_valid;
        l2_req_addr_n  = l2_req_addr;
        resp_valid_n   = 1'b0;
        resp_data_n    = resp_data;
        resp_err_n     = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_n  = req_addr;
                    l1_st_n = req_addr;
                    if (req_we) begin
                        state_n   = WRITE;
                        l1_mode_n = MODE_WRITE;
                        l1_in_n   = req_wdata;
                    end else begin
                        state_n   = LOOKUP;
                        l1_mode_n = MODE_READ;
                    end
                end
            end

            LOOKUP: begin
                if (l1_miss) begin
                    state_n        = MISS_REQ;
                    l2_req_valid_n = 1'b1;
                    l2_req_addr_n  = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_data_n  = l1_out;
                end
            end

            WRITE: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
                resp_data_n  = '0;
            end

            MISS_REQ: begin
                if (l2_req_ready) begin
                    state_n        = FILL;
                    l2_req_valid_n = 1'b0;
                    beat_n         = '0;
                end
            end

            // After the last beat, one more FILL cycle lets its L1 write land
            // before the replay read is issued; beats arriving then are dropped.
            FILL: begin
                if (beat == ALL_BEATS) begin
                    state_n   = REPLAY;
                    l1_mode_n = MODE_READ;
                    l1_st_n   = addr_q;
                end else if (l2_data_valid) begin
                    l1_mode_n = MODE_WRITE;
                    l1_st_n   = {addr_q[31:OFF_W], beat[OFF_W-1:0]};
                    l1_in_n   = l2_data;
                    beat_n    = (beat == LAST_BEAT) ? ALL_BEATS : beat + BW'(1);
                end
            end

            REPLAY: begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
                resp_data_n  = l1_out;
                resp_err_n   = l1_miss;
            end

            RESP: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            beat         <= '0;
            l1_mode      <= MODE_IDLE;
            l1_st        <= '0;
            l1_in        <= '0;
            l2_req_valid <= 1'b0;
            l2_req_addr  <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_err     <= 1'b0;
        end else begin
            state        <= state_n;
            addr_q       <= addr_n;
            beat         <= beat_n;
            l1_mode      <= l1_mode_n;
            l1_st        <= l1_st_n;
            l1_in        <= l1_in_n;
            l2_req_valid <= l2_req_valid_n;
            l2_req_addr  <= l2_req_addr_n;
            resp_valid   <= resp_valid_n;
            resp_data    <= resp_data_n;
            resp_err     <= resp_err_n;
        end
    end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Scoreboard bench for l1_refill_ctrl: behavioural L1/L2 models, a cache-contents
// reference model predicting responses, L1 writes and L2 requests per transaction.
module tb_l1_refill_ctrl;
    import l1_refill_pkg::*;

    localparam int LW = 16;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_err;
    logic [DW-1:0] resp_data;
    logic [1:0]    l1_mode;
    logic [31:0]   l1_st;
    logic [DW-1:0] l1_in, l1_out;
    logic          l1_miss;
    logic          l2_req_valid, l2_req_ready;
    logic [31:0]   l2_req_addr;
    logic          l2_data_valid;
    logic [DW-1:0] l2_data;
    logic          busy;

    l1_refill_ctrl #(.LINE_WORDS(LW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .l1_mode(l1_mode), .l1_st(l1_st), .l1_in(l1_in), .l1_out(l1_out), .l1_miss(l1_miss),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_addr(l2_req_addr),
        .l2_data_valid(l2_data_valid), .l2_data(l2_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] data; logic err; int lat; int unsigned acc; } resp_t;
    typedef struct { logic [31:0] addr; logic [63:0] data; } wr_t;

    resp_t       resp_q[$];
    wr_t         l1w_q[$];
    logic [31:0] l2a_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    int          wr_seen = 0;
    bit          hung = 0;

    logic [63:0] l1_mem  [bit [31:0]];
    logic [63:0] ref_mem [bit [31:0]];
    logic [63:0] l2line  [LW];
    bit          force_miss = 0;
    bit          noise_en = 0, rand_gaps = 0, extra_beat = 0;
    int          bp_cycles = 0, gap_after = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    // Behavioural L1: writes land on the falling edge, read data is presented for the next rising edge.
    always @(negedge clk) begin
        if (l1_mode == MODE_WRITE) l1_mem[l1_st] = l1_in;
        if (!force_miss && l1_mem.exists(l1_st)) begin
            l1_out  = l1_mem[l1_st];
            l1_miss = 1'b0;
        end else begin
            l1_out  = '0;
            l1_miss = 1'b1;
        end
    end

    resp_t mon_e;
    wr_t   mon_w;
    always @(negedge clk) begin
        if (rst_n) begin
            if (l1_mode == MODE_WRITE) begin
                wr_seen++;
                if (l1w_q.size() == 0) flag("unexpected_l1_write");
                else begin
                    mon_w = l1w_q.pop_front();
                    check("l1_write_st", l1_st, mon_w.addr);
                    check("l1_write_in", l1_in, mon_w.data);
                end
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) flag("unexpected_resp");
                else begin
                    mon_e = resp_q.pop_front();
                    check("resp_data", resp_data, mon_e.data);
                    check("resp_err", resp_err, mon_e.err);
                    if (mon_e.lat != 0) check("resp_latency", cyc - mon_e.acc, mon_e.lat);
                end
                check("resp_l1_mode_idle", l1_mode, MODE_IDLE);
                check("resp_req_ready", req_ready, 0);
            end
        end
    end

    task automatic serve_line();
        repeat (bp_cycles) begin
            @(negedge clk);
            if (!rst_n) return;
            check("l2_req_valid_hold", l2_req_valid, 1);
        end
        if (l2a_q.size() == 0) flag("unexpected_l2_req");
        else check("l2_req_addr", l2_req_addr, l2a_q.pop_front());
        l2_req_ready = 1'b1;
        @(negedge clk);
        l2_req_ready = 1'b0;
        if (!rst_n) return;
        for (int k = 0; k < LW; k++) begin
            if (k > 0 && (k == gap_after + 1 || (rand_gaps && $urandom_range(0, 3) == 0))) begin
                l2_data_valid = 1'b0;
                l2_data       = {$urandom, $urandom};
                @(negedge clk);
                if (!rst_n) return;
                check("gap_l1_mode_idle", l1_mode, MODE_IDLE);
            end
            l2_data_valid = 1'b1;
            l2_data       = l2line[k];
            @(negedge clk);
            if (!rst_n) return;
        end
        if (extra_beat) begin
            l2_data_valid = 1'b1;
            l2_data       = {$urandom, $urandom};
            @(negedge clk);
        end
        l2_data_valid = 1'b0;
    endtask

    initial begin : l2_side
        l2_req_ready  = 1'b0;
        l2_data_valid = 1'b0;
        l2_data       = '0;
        forever begin
            @(negedge clk);
            if (rst_n && l2_req_valid) begin
                serve_line();
                l2_req_ready  = 1'b0;
                l2_data_valid = 1'b0;
            end else begin
                l2_data_valid = noise_en && ($urandom_range(0, 3) == 0);
                l2_data       = {$urandom, $urandom};
            end
        end
    end

    // Reference: a word hits iff it has been written or refilled since time zero.
    task automatic predict(input bit we, input logic [31:0] a, input logic [63:0] d);
        resp_t       r;
        wr_t         w;
        logic [31:0] line;
        r.acc = cyc; r.err = 1'b0; r.lat = 0; r.data = '0;
        if (we) begin
            ref_mem[a] = d;
            w.addr = a; w.data = d;
            l1w_q.push_back(w);
            r.lat = 2;
        end else if (!force_miss && ref_mem.exists(a)) begin
            r.data = ref_mem[a];
            r.lat  = 2;
        end else begin
            line = a & ~32'(LW - 1);
            l2a_q.push_back(line);
            for (int k = 0; k < LW; k++) begin
                w.addr = line + 32'(k); w.data = l2line[k];
                l1w_q.push_back(w);
                ref_mem[line + 32'(k)] = l2line[k];
            end
            r.data = force_miss ? 64'h0 : l2line[int'(a % 32'(LW))];
            r.err  = force_miss;
        end
        resp_q.push_back(r);
    endtask

    task automatic issue(input bit we, input logic [31:0] a, input logic [63:0] d);
        int t = 0;
        while (!req_ready && t < 400) begin @(negedge clk); t++; end
        if (!req_ready) begin flag("issue_timeout"); hung = 1; return; end
        predict(we, a, d);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = {$urandom, $urandom};
    endtask

    task automatic wait_done();
        int t = 0;
        while (resp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
        if (resp_q.size() != 0) begin
            flag("resp_timeout");
            hung = 1;
            resp_q.delete(); l1w_q.delete(); l2a_q.delete();
        end
        @(negedge clk); #1;
        check("idle_busy", busy, 0);
        check("idle_l1_mode", l1_mode, MODE_IDLE);
        check("pending_l1_writes", l1w_q.size(), 0);
        check("pending_l2_reqs", l2a_q.size(), 0);
    endtask

    task automatic rand_line();
        for (int k = 0; k < LW; k++) l2line[k] = {$urandom, $urandom};
    endtask

    logic [27:0] pool [5] = '{28'h0000010, 28'h0000011, 28'h0000200, 28'h00007FF, 28'hFFFFFFF};

    initial begin : main
        int t, target;
        logic [31:0] a;
        bit we;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_l1_mode", l1_mode, MODE_IDLE);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_l1_st", l1_st, 0);
        check("rst_l1_in", l1_in, 0);
        check("rst_l2_req_valid", l2_req_valid, 0);
        check("rst_l2_req_addr", l2_req_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", req_ready, 1);

        // Hit on a preloaded word
        l1_mem[32'h11] = 64'hAAAA; ref_mem[32'h11] = 64'hAAAA;
        issue(0, 32'h0000_0011, '0); wait_done();

        // Full-line miss, beats k+1
        for (int k = 0; k < LW; k++) l2line[k] = 64'(k + 1);
        issue(0, 32'h0000_2013, '0); wait_done();

        // Backpressure and a gap after beat 7, plus an extra trailing beat
        rand_line(); bp_cycles = 5; gap_after = 7; extra_beat = 1;
        issue(0, 32'h0000_4000, '0); wait_done();
        bp_cycles = 0; gap_after = -1; extra_beat = 0;

        issue(1, 32'h0000_0005, 64'h1234); wait_done();
        issue(0, 32'h0000_0005, '0); wait_done();

        // Replay still missing
        rand_line(); force_miss = 1;
        issue(0, 32'h0000_6007, '0); wait_done();
        force_miss = 0;

        // Reset after beat 6 has been written
        rand_line();
        target = wr_seen + 7;
        issue(0, 32'h0000_3009, '0);
        t = 0;
        do begin @(negedge clk); #1; t++; end while (wr_seen < target && t < 200);
        check("abort_beats_written", wr_seen, target);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_l1_mode", l1_mode, MODE_IDLE);
        check("abort_req_ready", req_ready, 0);
        check("abort_l2_req_valid", l2_req_valid, 0);
        check("abort_resp_valid", resp_valid, 0);
        resp_q.delete(); l1w_q.delete(); l2a_q.delete();
        for (int k = 7; k < LW; k++) ref_mem.delete(32'h3000 + 32'(k));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 32'h0000_3002, '0); wait_done();

        // Randomised traffic over a few lines
        noise_en = 1; rand_gaps = 1;
        for (int n = 0; n < 150; n++) begin
            if (hung) break;
            a  = {pool[$urandom_range(0, 4)], 4'($urandom_range(0, 15))};
            we = ($urandom_range(0, 9) < 3);
            force_miss = !we && ($urandom_range(0, 9) == 0);
            bp_cycles  = $urandom_range(0, 3);
            extra_beat = 1'($urandom_range(0, 1));
            rand_line();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(we, a, {$urandom, $urandom});
            wait_done();
            force_miss = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion, expected finish within 50000 cycles");
        $fatal(1, "bench stalled");
    end

endmodule
